// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and state type for the RV32I fetch stage
//   RESET_PC     : PC loaded on reset
//   PC_INC       : sequential PC increment (byte addressing)
//   NOP_INSTR    : bubble word (addi x0,x0,0)
//   EBREAK_INSTR : encoding that halts fetch
//   if_state_t   : fetch FSM states {BOOT, RUN, HALT}
package core_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: hazard/redirect inputs, imem port, IF/ID outputs
//   master : the fetch stage (drives imem_pc_o, ifid_*, halted_o)
//   slave  : the surrounding core / instruction memory
interface if_stage_if;

  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_instr_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;
  logic        halted_o;

  modport master (
    input  stall_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    input  imem_instr_i,
    output imem_pc_o,
    output ifid_valid_o,
    output ifid_pc_o,
    output ifid_pc4_o,
    output ifid_instr_o,
    output halted_o
  );

  modport slave (
    output stall_i,
    output redirect_valid_i,
    output redirect_pc_i,
    output imem_instr_i,
    input  imem_pc_o,
    input  ifid_valid_o,
    input  ifid_pc_o,
    input  ifid_pc4_o,
    input  ifid_instr_o,
    input  halted_o
  );

endinterface

// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - program counter register and next-PC selection
//   clk, rst_n       : clock, synchronous active-low reset
//   state_i          : current fetch FSM state
//   stall_i          : hold PC
//   redirect_valid_i : load redirect_pc_i (wins over stall)
//   redirect_pc_i    : redirect target, used verbatim
//   ebreak_i         : word being fetched is ebreak, do not step past it
//   pc_o             : current PC
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
  parameter logic [31:0] PC_INC   = core_pkg::PC_INC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  core_pkg::if_state_t state_i,
  input  logic                stall_i,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  input  logic                ebreak_i,
  output logic [31:0]         pc_o
);
  import core_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    case (state_i)
      RUN: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end else if (!stall_i && !ebreak_i) begin
          // 32-bit add wraps naturally at 2^32
          pc_d = pc_q + PC_INC;
        end
      end
      HALT: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
      end
      default: begin
        // BOOT: bubble cycle, PC not advanced
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage with IF/ID register and ebreak halt
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : if_stage_if.master (stall/redirect in, imem port, IF/ID out, halted_o)
//   perf_fetch_o, perf_stall_o, perf_flush_o : present only with IF_PERF_CNT_EN defined
module if_stage #(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] PC_INC    = core_pkg::PC_INC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o
`endif
);
  import core_pkg::*;

  if_state_t   state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] pc;
  logic        fetch_is_ebreak;
  logic        ev_fetch, ev_stall, ev_flush;

  assign fetch_is_ebreak = (bus.imem_instr_i == EBREAK_INSTR);

  if_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .state_i          (state_q),
    .stall_i          (bus.stall_i),
    .redirect_valid_i (bus.redirect_valid_i),
    .redirect_pc_i    (bus.redirect_pc_i),
    .ebreak_i         (fetch_is_ebreak),
    .pc_o             (pc)
  );

  always_comb begin
    state_d      = state_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ev_fetch     = 1'b0;
    ev_stall     = 1'b0;
    ev_flush     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          ev_flush     = 1'b1;
        end else if (bus.stall_i) begin
          ev_stall = 1'b1;
        end else begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = pc;
          ifid_pc4_d   = pc + PC_INC;
          ifid_instr_d = bus.imem_instr_i;
          ev_fetch     = 1'b1;
          // ebreak still enters IF/ID; fetch stops behind it
          if (fetch_is_ebreak) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        if (bus.redirect_valid_i) begin
          state_d  = RUN;
          ev_flush = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign bus.imem_pc_o    = pc;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.ifid_pc_o    = ifid_pc_q;
  assign bus.ifid_pc4_o   = ifid_pc4_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.halted_o     = (state_q == HALT);

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'h0, ev_fetch};
    perf_stall_d = perf_stall_q + {31'h0, ev_stall};
    perf_flush_d = perf_flush_q + {31'h0, ev_flush};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`else
  logic unused_ev;
  assign unused_ev = ev_fetch ^ ev_stall ^ ev_flush;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch),
    .perf_stall_o (perf_stall),
    .perf_flush_o (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    if (a == 32'h0000_0020) return 32'h0010_0073;
    return {a[23:0], 8'h33};
  endfunction

  always_comb bus.imem_instr_i = imem_model(bus.imem_pc_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    step();
    step();
    checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL rst_valid got %h exp 0", bus.ifid_valid_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h13) $display("FAIL rst_instr got %h exp 00000013", bus.ifid_instr_o); else passed++;
    checks++; if (bus.ifid_pc_o !== 32'h0) $display("FAIL rst_pc got %h exp 0", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_pc4_o !== 32'h0) $display("FAIL rst_pc4 got %h exp 0", bus.ifid_pc4_o); else passed++;
    checks++; if (bus.halted_o !== 1'b0) $display("FAIL rst_halted got %h exp 0", bus.halted_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h0) $display("FAIL rst_imem_pc got %h exp 0", bus.imem_pc_o); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL boot_valid got %h exp 0", bus.ifid_valid_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h0) $display("FAIL boot_imem_pc got %h exp 0", bus.imem_pc_o); else passed++;
    step();
    checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL first_valid got %h exp 1", bus.ifid_valid_o); else passed++;
    checks++; if (bus.ifid_pc_o !== 32'h0) $display("FAIL first_pc got %h exp 0", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h0050_0093) $display("FAIL first_instr got %h exp 00500093", bus.ifid_instr_o); else passed++;
    checks++; if (bus.ifid_pc4_o !== 32'h4) $display("FAIL first_pc4 got %h exp 4", bus.ifid_pc4_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h4) $display("FAIL first_imem_pc got %h exp 4", bus.imem_pc_o); else passed++;
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    while (bus.imem_pc_o !== 32'h10 && n < 10) begin
      step();
      n++;
    end
    checks++; if (bus.imem_pc_o !== 32'h10) $display("FAIL stall_reach got %h exp 10", bus.imem_pc_o); else passed++;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_pc_o !== 32'h10) $display("FAIL stall_imem_pc[%0d] got %h exp 10", i, bus.imem_pc_o); else passed++;
      checks++; if (bus.ifid_pc_o !== 32'hC) $display("FAIL stall_ifid_pc[%0d] got %h exp c", i, bus.ifid_pc_o); else passed++;
      checks++; if (bus.ifid_instr_o !== 32'h0000_0C33) $display("FAIL stall_instr[%0d] got %h exp 00000c33", i, bus.ifid_instr_o); else passed++;
      checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL stall_valid[%0d] got %h exp 1", i, bus.ifid_valid_o); else passed++;
    end
    bus.stall_i = 1'b0;
    step();
    checks++; if (bus.ifid_pc_o !== 32'h10) $display("FAIL resume_pc got %h exp 10", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h0000_1033) $display("FAIL resume_instr got %h exp 00001033", bus.ifid_instr_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h14) $display("FAIL resume_imem_pc got %h exp 14", bus.imem_pc_o); else passed++;
  endtask

  task automatic test_redirect_stall();
    bus.stall_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h40;
    step();
    checks++; if (bus.imem_pc_o !== 32'h40) $display("FAIL redir_imem_pc got %h exp 40", bus.imem_pc_o); else passed++;
    checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL redir_valid got %h exp 0", bus.ifid_valid_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h13) $display("FAIL redir_instr got %h exp 00000013", bus.ifid_instr_o); else passed++;
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    step();
    checks++; if (bus.ifid_pc_o !== 32'h40) $display("FAIL redir_next_pc got %h exp 40", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL redir_next_valid got %h exp 1", bus.ifid_valid_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h44) $display("FAIL redir_next_imem got %h exp 44", bus.imem_pc_o); else passed++;
  endtask

  task automatic test_ebreak();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h1C;
    step();
    bus.redirect_valid_i = 1'b0;
    step();
    checks++; if (bus.ifid_pc_o !== 32'h1C) $display("FAIL eb_pre_pc got %h exp 1c", bus.ifid_pc_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h20) $display("FAIL eb_pre_imem got %h exp 20", bus.imem_pc_o); else passed++;
    step();
    checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL eb_valid got %h exp 1", bus.ifid_valid_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h0010_0073) $display("FAIL eb_instr got %h exp 00100073", bus.ifid_instr_o); else passed++;
    checks++; if (bus.ifid_pc_o !== 32'h20) $display("FAIL eb_pc got %h exp 20", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_pc4_o !== 32'h24) $display("FAIL eb_pc4 got %h exp 24", bus.ifid_pc4_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h20) $display("FAIL eb_imem got %h exp 20", bus.imem_pc_o); else passed++;
    checks++; if (bus.halted_o !== 1'b1) $display("FAIL eb_halted got %h exp 1", bus.halted_o); else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL halt_valid[%0d] got %h exp 0", i, bus.ifid_valid_o); else passed++;
      checks++; if (bus.ifid_instr_o !== 32'h13) $display("FAIL halt_instr[%0d] got %h exp 00000013", i, bus.ifid_instr_o); else passed++;
      checks++; if (bus.halted_o !== 1'b1) $display("FAIL halt_halted[%0d] got %h exp 1", i, bus.halted_o); else passed++;
      checks++; if (bus.imem_pc_o !== 32'h20) $display("FAIL halt_imem[%0d] got %h exp 20", i, bus.imem_pc_o); else passed++;
    end
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h0;
    step();
    bus.redirect_valid_i = 1'b0;
    checks++; if (bus.halted_o !== 1'b0) $display("FAIL unhalt_halted got %h exp 0", bus.halted_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h0) $display("FAIL unhalt_imem got %h exp 0", bus.imem_pc_o); else passed++;
    step();
    checks++; if (bus.ifid_instr_o !== 32'h0050_0093) $display("FAIL unhalt_instr got %h exp 00500093", bus.ifid_instr_o); else passed++;
    checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL unhalt_valid got %h exp 1", bus.ifid_valid_o); else passed++;
  endtask

  task automatic test_wrap();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid_i = 1'b0;
    step();
    checks++; if (bus.ifid_pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp fffffffc", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_pc4_o !== 32'h0) $display("FAIL wrap_pc4 got %h exp 0", bus.ifid_pc4_o); else passed++;
    checks++; if (bus.imem_pc_o !== 32'h0) $display("FAIL wrap_imem got %h exp 0", bus.imem_pc_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'hFFFF_FC33) $display("FAIL wrap_instr got %h exp fffffc33", bus.ifid_instr_o); else passed++;
  endtask

  task automatic test_mid_reset();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h80;
    step();
    bus.redirect_valid_i = 1'b0;
    step();
    checks++; if (bus.imem_pc_o !== 32'h84) $display("FAIL mrst_pre_imem got %h exp 84", bus.imem_pc_o); else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (bus.imem_pc_o !== 32'h0) $display("FAIL mrst_imem got %h exp 0", bus.imem_pc_o); else passed++;
    checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL mrst_valid got %h exp 0", bus.ifid_valid_o); else passed++;
    checks++; if (bus.ifid_instr_o !== 32'h13) $display("FAIL mrst_instr got %h exp 00000013", bus.ifid_instr_o); else passed++;
`ifdef IF_PERF_CNT_EN
    checks++; if (perf_fetch !== 32'h0) $display("FAIL mrst_perf_fetch got %h exp 0", perf_fetch); else passed++;
    checks++; if (perf_stall !== 32'h0) $display("FAIL mrst_perf_stall got %h exp 0", perf_stall); else passed++;
    checks++; if (perf_flush !== 32'h0) $display("FAIL mrst_perf_flush got %h exp 0", perf_flush); else passed++;
`endif
    step();
    checks++; if (bus.ifid_valid_o !== 1'b0) $display("FAIL mrst_boot_valid got %h exp 0", bus.ifid_valid_o); else passed++;
    step();
    checks++; if (bus.ifid_pc_o !== 32'h0) $display("FAIL mrst_run_pc got %h exp 0", bus.ifid_pc_o); else passed++;
    checks++; if (bus.ifid_valid_o !== 1'b1) $display("FAIL mrst_run_valid got %h exp 1", bus.ifid_valid_o); else passed++;
`ifdef IF_PERF_CNT_EN
    bus.stall_i = 1'b1;
    step();
    step();
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    step();
    bus.redirect_valid_i = 1'b0;
    step();
    checks++; if (perf_fetch !== 32'd2) $display("FAIL perf_fetch got %0d exp 2", perf_fetch); else passed++;
    checks++; if (perf_stall !== 32'd2) $display("FAIL perf_stall got %0d exp 2", perf_stall); else passed++;
    checks++; if (perf_flush !== 32'd1) $display("FAIL perf_flush got %0d exp 1", perf_flush); else passed++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_stall();
    test_redirect_stall();
    test_ebreak();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
